// File: rtl/i2c_pkg.sv
// Shared types for the I2C transmit feeder: FSM states, byte width and FIFO entry layout.
package i2c_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWaitDone
  } state_e;

  typedef struct packed {
    logic             last;
    logic [ByteW-1:0] data;
  } entry_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// First-word-fall-through byte FIFO with frame-end flag, occupancy count and flush.
module i2c_byte_fifo
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     wr_entry,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Self-protecting: writes when full and reads when empty are dropped.
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage array, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_tx_feeder.sv
// Frame-aware byte feeder for an I2C master transmitter. A frame is only offered to the
// transmitter once its last byte is queued, so a started frame never starves.
// Optional WAIT_DONE watchdog enabled by defining I2C_FEEDER_TIMEOUT_EN.
module i2c_tx_feeder
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ByteW-1:0] wr_data,
  input  logic             wr_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [ByteW-1:0] tx_data,
  output logic             tx_data_ready,
  output logic             tx_en,
  input  logic             tx_data_req,
  input  logic             tx_done,
  output logic             busy,
  output logic             err_frame,
  output logic             timeout
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e        state_q;
  logic [CW-1:0] frames_q;
  logic          err_q;
  entry_t        head;
  entry_t        wr_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic          overflow;
  logic          tmo_hit;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr_entry  = {wr_last, wr_data};
  assign push      = wr_valid && !full;
  assign pop       = tx_data_req && tx_data_ready;
  assign push_last = push && wr_last;
  assign pop_last  = pop && head.last;
  // A full FIFO with no complete frame can never drain: drop everything.
  assign overflow  = full && (frames_q == '0);

  assign wr_ready      = !full;
  assign tx_data       = head.data;
  assign tx_en         = (state_q == StXfer);
  assign tx_data_ready = tx_en && !empty;
  assign busy          = (state_q != StIdle);
  assign err_frame     = err_q;

  i2c_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (overflow),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Count of complete frames whose last byte is still queued.
  always_ff @(posedge clk) begin
    if (!rst_n || overflow) begin
      frames_q <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   frames_q <= frames_q + 1'b1;
        2'b01:   frames_q <= frames_q - 1'b1;
        default: frames_q <= frames_q;
      endcase
    end
  end

  // Frame sequencing FSM and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else if (overflow) begin
      state_q <= StIdle;
      err_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle:     if (frames_q != '0) state_q <= StXfer;
        StXfer:     if (pop_last) state_q <= StWaitDone;
        StWaitDone: if (tx_done || tmo_hit) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

`ifdef I2C_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  assign tmo_hit = (state_q == StWaitDone) && !tx_done &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Cycles spent in WAIT_DONE; cleared in every other state.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_q != StWaitDone)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // One-cycle abort pulse, coincident with the return to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit && !overflow;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Self-checking bench for i2c_tx_feeder: directed scenarios plus a randomized phase
// scored against a queue-based model of the feeder's frame rules.
module tb_i2c_tx_feeder;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_en;
  logic       tx_data_req = 1'b0;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       err_frame;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes queued in the FIFO, bytes still to be written, and frame phase
  // (0 = no frame offered, 1 = frame offered, 2 = waiting for STOP completion).
  logic [8:0] mq[$];
  logic [8:0] src[$];
  int         phase;
  int         wd_cnt;
  int         wd_delay;

  i2c_tx_feeder #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_en         (tx_en),
    .tx_data_req   (tx_data_req),
    .tx_done       (tx_done),
    .busy          (busy),
    .err_frame     (err_frame),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic l);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    @(negedge clk);
    check("wr_ready_on_write", wr_ready, 1'b1);
    next_cycle;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pop_byte(input logic [7:0] exp);
    tx_data_req = 1'b1;
    @(negedge clk);
    check("pop_data_ready", tx_data_ready, 1'b1);
    check("pop_data", tx_data, exp);
    next_cycle;
    tx_data_req = 1'b0;
  endtask

  task automatic finish_frame;
    tx_done = 1'b1;
    next_cycle;
    tx_done = 1'b0;
    @(negedge clk);
    check("done_busy_low", busy, 1'b0);
    check("done_tx_en_low", tx_en, 1'b0);
    next_cycle;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) next_cycle;
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n, input bit allow_new);
    int len;
    bit acc;
    bit pp;
    int pend;
    int nxt;
    for (int c = 0; c < n; c++) begin
      if (allow_new && (src.size() == 0) && ($urandom_range(0, 3) == 0)) begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) src.push_back({(i == len - 1), 8'($urandom)});
      end
      wr_valid = 1'b0;
      wr_data  = 8'($urandom);
      wr_last  = 1'($urandom_range(0, 1));
      if ((src.size() != 0) && ($urandom_range(0, 9) < 7)) begin
        wr_valid = 1'b1;
        wr_data  = src[0][7:0];
        wr_last  = src[0][8];
      end
      tx_data_req = ($urandom_range(0, 1) == 1);
      if (phase == 2) begin
        tx_done = (wd_cnt == wd_delay);
        wd_cnt++;
      end else begin
        tx_done = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      check("rnd_wr_ready", wr_ready, (mq.size() < DEPTH));
      check("rnd_tx_en", tx_en, (phase == 1));
      check("rnd_tx_data_ready", tx_data_ready, (phase == 1) && (mq.size() > 0));
      check("rnd_busy", busy, (phase != 0));
      check("rnd_err_frame", err_frame, 1'b0);
      check("rnd_timeout", timeout, 1'b0);
      if ((phase == 1) && (mq.size() > 0)) check("rnd_tx_data", tx_data, mq[0][7:0]);
      acc  = wr_valid && (mq.size() < DEPTH);
      pp   = tx_data_req && (phase == 1) && (mq.size() > 0);
      pend = 0;
      foreach (mq[i]) if (mq[i][8]) pend++;
      nxt = phase;
      case (phase)
        0:       if (pend > 0) nxt = 1;
        1:       if (pp && mq[0][8]) nxt = 2;
        default: if (tx_done) nxt = 0;
      endcase
      next_cycle;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(src[0]);
        void'(src.pop_front());
      end
      if ((nxt == 2) && (phase != 2)) begin
        wd_cnt   = 0;
        wd_delay = $urandom_range(0, 4);
      end
      phase = nxt;
    end
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    tx_data_req = 1'b0;
    tx_done     = 1'b0;
  endtask

  initial begin
    // Reset with a write held active: nothing may be accepted.
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    wr_data  = 8'h99;
    do_reset;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data_ready", tx_data_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_frame", err_frame, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    next_cycle;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_accept", tx_en, 1'b0);
      next_cycle;
    end

    // Single frame.
    write_byte(8'hA0, 1'b0);
    write_byte(8'h10, 1'b0);
    write_byte(8'h55, 1'b1);
    @(negedge clk);
    check("single_start_lat1", tx_en, 1'b0);
    next_cycle;
    @(negedge clk);
    check("single_tx_en", tx_en, 1'b1);
    check("single_data_ready", tx_data_ready, 1'b1);
    check("single_busy", busy, 1'b1);
    next_cycle;
    pop_byte(8'hA0);
    pop_byte(8'h10);
    pop_byte(8'h55);
    tx_data_req = 1'b1;
    @(negedge clk);
    check("single_stop_tx_en", tx_en, 1'b0);
    check("single_stop_ready", tx_data_ready, 1'b0);
    check("single_wait_busy", busy, 1'b1);
    next_cycle;
    tx_data_req = 1'b0;
    finish_frame;

    // Back-to-back frames with a request driven while IDLE.
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b0);
    write_byte(8'h03, 1'b1);
    pop_byte(8'h01);
    @(negedge clk);
    check("b2b_stop", tx_en, 1'b0);
    next_cycle;
    tx_done = 1'b1;
    next_cycle;
    tx_done     = 1'b0;
    tx_data_req = 1'b1;
    @(negedge clk);
    check("b2b_idle_tx_en", tx_en, 1'b0);
    check("b2b_idle_busy", busy, 1'b0);
    next_cycle;
    tx_data_req = 1'b0;
    tx_done     = 1'b1;
    @(negedge clk);
    check("b2b_restart", tx_en, 1'b1);
    check("b2b_head", tx_data, 8'h02);
    next_cycle;
    tx_done = 1'b0;
    @(negedge clk);
    check("b2b_done_in_xfer_ignored", tx_en, 1'b1);
    next_cycle;
    pop_byte(8'h02);
    pop_byte(8'h03);
    finish_frame;

    // Incomplete frame holds off the transmitter.
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tx_done = (i == 1);
      @(negedge clk);
      check("partial_tx_en", tx_en, 1'b0);
      check("partial_busy", busy, 1'b0);
      next_cycle;
    end
    tx_done = 1'b0;
    write_byte(8'h33, 1'b1);
    @(negedge clk);
    check("partial_start_lat1", tx_en, 1'b0);
    next_cycle;
    @(negedge clk);
    check("partial_start_lat2", tx_en, 1'b1);
    next_cycle;
    pop_byte(8'h11);
    pop_byte(8'h22);
    pop_byte(8'h33);
    next_cycle;
    finish_frame;

    // Overflow without any complete frame.
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h40 + i), 1'b0);
    @(negedge clk);
    check("ovf_full_wr_ready", wr_ready, 1'b0);
    next_cycle;
    @(negedge clk);
    check("ovf_err_frame", err_frame, 1'b1);
    check("ovf_flushed", wr_ready, 1'b1);
    check("ovf_tx_en", tx_en, 1'b0);
    next_cycle;
    write_byte(8'h77, 1'b1);
    next_cycle;
    @(negedge clk);
    check("ovf_fresh_tx_en", tx_en, 1'b1);
    check("ovf_fresh_data", tx_data, 8'h77);
    next_cycle;
    pop_byte(8'h77);
    next_cycle;
    finish_frame;
    @(negedge clk);
    check("ovf_err_sticky", err_frame, 1'b1);
    next_cycle;
    do_reset;
    @(negedge clk);
    check("ovf_err_cleared", err_frame, 1'b0);
    next_cycle;

`ifdef I2C_FEEDER_TIMEOUT_EN
    // Withhold tx_done: abort exactly TIMEOUT_CYCLES after WAIT_DONE entry.
    write_byte(8'h5A, 1'b1);
    next_cycle;
    pop_byte(8'h5A);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("tmo_quiet", timeout, 1'b0);
      check("tmo_busy", busy, 1'b1);
      next_cycle;
    end
    @(negedge clk);
    check("tmo_pulse", timeout, 1'b1);
    check("tmo_idle", busy, 1'b0);
    next_cycle;
    @(negedge clk);
    check("tmo_one_cycle", timeout, 1'b0);
    next_cycle;
    do_reset;
`endif

    // Randomized traffic, then drain.
    phase    = 0;
    wd_cnt   = 0;
    wd_delay = 0;
    mq.delete();
    src.delete();
    run_random(3000, 1'b1);
    run_random(600, 1'b0);
    check("drain_model_empty", mq.size() + src.size(), 0);
    @(negedge clk);
    check("drain_tx_en", tx_en, 1'b0);
    check("drain_busy", busy, 1'b0);
    check("drain_wr_ready", wr_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_tx_feeder.md
I2C_TX_FEEDER -- requirements
Module: i2c_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, minimum 4.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, clk cycles allowed in WAIT_DONE before abort; used only when the timeout feature is compiled in.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 wr_data  in  8  byte to queue for I2C transmission.
REQ-006 wr_last  in  1  qualifies wr_data as the final byte of a frame.
REQ-007 wr_valid  in  1  write request; a byte is accepted when wr_valid and wr_ready are both high.
REQ-008 wr_ready  out  1  high when the FIFO is not full.
REQ-009 tx_data  out  8  FIFO head byte, first-word-fall-through, to the transmitter data input.
REQ-010 tx_data_ready  out  1  a byte of the current frame is available, to the transmitter data_ready input.
REQ-011 tx_en  out  1  frame in progress, to the transmitter en input.
REQ-012 tx_data_req  in  1  one-cycle byte request from the transmitter.
REQ-013 tx_done  in  1  one-cycle end-of-STOP pulse from the transmitter.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 err_frame  out  1  sticky; set on an unframeable overflow.
REQ-016 timeout  out  1  one-cycle pulse on a WAIT_DONE abort.

Function
REQ-017 The FIFO SHALL store 9-bit entries {last, data}, with read/write pointers that wrap modulo DEPTH and a separate occupancy count from 0 to DEPTH.
REQ-018 frames_pending SHALL increment on each accepted wr_last byte and decrement on each popped last byte; on the same cycle as both events it SHALL remain unchanged.
REQ-019 A pop SHALL occur exactly on cycles where tx_data_req and tx_data_ready are both high; tx_data SHALL be valid combinationally on that cycle.
REQ-020 wr_ready SHALL be low when the FIFO is full, including when a pop occurs on the same cycle.
REQ-021 The FSM SHALL have three states: IDLE, XFER and WAIT_DONE.
REQ-022 IDLE -> XFER on the cycle after frames_pending becomes nonzero, so that tx_en and tx_data_ready are high 2 cycles after the wr_last handshake.
REQ-023 In XFER, tx_en SHALL be 1 and tx_data_ready SHALL equal "FIFO not empty".
REQ-024 XFER -> WAIT_DONE on a pop of a last byte; tx_data_ready and tx_en SHALL be 0 from the next cycle, so the transmitter issues STOP.
REQ-025 WAIT_DONE -> IDLE on tx_done; if frames_pending is nonzero, the FSM SHALL re-enter XFER one cycle later.
REQ-026 No frame SHALL start until its last byte is queued, so a started frame never starves mid-transfer.
REQ-027 If the FIFO is full while frames_pending is 0, the block SHALL set err_frame, flush the FIFO to empty on the next cycle and return to IDLE.
REQ-028 tx_data_req outside XFER SHALL be ignored, with no pop.
REQ-029 tx_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-030 While rst_n is low at a clock edge, the FSM SHALL be set to IDLE, pointers, count and frames_pending to 0, and err_frame to 0.
REQ-031 Output reset values SHALL be: wr_ready=1 (from the next cycle), tx_data_ready=0, tx_en=0, busy=0, timeout=0; tx_data is don't-care.
REQ-032 Reset mid-frame SHALL discard all queued bytes; a partially sent I2C frame is not resumed.

Configuration
REQ-033 Macro I2C_FEEDER_TIMEOUT_EN: when defined, a counter SHALL run in WAIT_DONE; on reaching TIMEOUT_CYCLES without tx_done, the block SHALL pulse timeout and move to IDLE.
REQ-034 When I2C_FEEDER_TIMEOUT_EN is undefined, WAIT_DONE SHALL wait indefinitely, timeout SHALL be tied to 0, and no counter SHALL be synthesised.

Structure
REQ-035 A shared package i2c_pkg SHALL hold the FSM state enum, the byte width constant (8) and the FIFO entry typedef {last, data}.
REQ-036 The FIFO SHALL be one sub-module, i2c_byte_fifo (FWFT, DEPTH parameter, count output, flush input); the FSM and frame counting SHALL live in the top module.

Verification
REQ-037 Reset: hold rst_n low 3 cycles with wr_valid=1 -> no byte accepted, all outputs at their reset values, wr_ready=1 on the first cycle after release.
REQ-038 Single frame: write 0xA0, 0x10, 0x55(last); pulse tx_data_req 3 times -> tx_data reads 0xA0, 0x10, 0x55; tx_en=0 after the third pop; tx_done returns busy to 0.
REQ-039 Back-to-back frames: queue frame {0x01(last)} then frame {0x02, 0x03(last)} -> the second frame's tx_en rises 1 cycle after the first frame's tx_done.
REQ-040 Incomplete frame: write 0x11, 0x22 without last -> tx_en stays 0; writing 0x33(last) raises tx_en 2 cycles later.
REQ-041 Overflow: write DEPTH (16) bytes with no last -> wr_ready=0, err_frame=1, count=0 one cycle later, err_frame stays 1 until reset.
REQ-042 With I2C_FEEDER_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: complete a frame and withhold tx_done -> timeout pulses exactly 8 cycles after WAIT_DONE entry, then state is IDLE.
